// File: rtl/calc1_port_seq.sv
// Queues calc1 requests and plays them onto a single calc1 port one at a time:
// CMD/op1, DATA/op2, bounded wait for a response, then a held result for handshake.
module calc1_port_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state_reg, state_next;

  // request FIFO storage
  logic [3:0]  cmd_mem [DEPTH];
  logic [31:0] op1_mem [DEPTH];
  logic [31:0] op2_mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          in_ready_reg;
  logic          push, pop, fifo_empty;
  logic [3:0]    head_cmd;

  logic [3:0]  cur_cmd_reg;
  logic [31:0] cur_op1_reg, cur_op2_reg;

  logic [TW-1:0] wait_cnt_reg, wait_cnt_next;

  logic          cap_en;
  logic [1:0]    cap_resp;
  logic [31:0]   cap_data;
  logic          cap_timeout;

  logic [3:0]  req_cmd_reg;
  logic [31:0] req_data_reg;
  logic        res_valid_reg;
  logic [1:0]  res_resp_reg;
  logic [31:0] res_data_reg;
  logic        res_timeout_reg;
  logic        busy_reg;

  assign fifo_empty = (count_reg == '0);
  assign push       = in_valid & in_ready_reg;
  assign pop        = (state_reg == S_IDLE) & ~fifo_empty;
  assign head_cmd   = cmd_mem[rd_ptr_reg];

  always_ff @(posedge c_clk) begin
    if (push) begin
      cmd_mem[wr_ptr_reg] <= in_cmd;
      op1_mem[wr_ptr_reg] <= in_op1;
      op2_mem[wr_ptr_reg] <= in_op2;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // in_ready follows the post-edge occupancy, so a full FIFO never accepts
  // even when a pop happens in the same cycle.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg    <= count_next;
      in_ready_reg <= (count_next < DEPTH_C);
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cur_cmd_reg <= '0;
      cur_op1_reg <= '0;
      cur_op2_reg <= '0;
    end else if (pop && head_cmd != 4'd0) begin
      cur_cmd_reg <= cmd_mem[rd_ptr_reg];
      cur_op1_reg <= op1_mem[rd_ptr_reg];
      cur_op2_reg <= op2_mem[rd_ptr_reg];
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    cap_en        = 1'b0;
    cap_resp      = 2'd0;
    cap_data      = 32'd0;
    cap_timeout   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // a zero command is popped and dropped without leaving IDLE
        if (!fifo_empty && head_cmd != 4'd0) state_next = S_CMD;
      end
      S_CMD: state_next = S_DATA;
      S_DATA: begin
        state_next    = S_WAIT;
        wait_cnt_next = '0;
      end
      S_WAIT: begin
        wait_cnt_next = wait_cnt_reg + TW'(1);
        if (out_resp != 2'd0) begin
          state_next  = S_HOLD;
          cap_en      = 1'b1;
          cap_resp    = out_resp;
          cap_data    = out_data;
        end else if (wait_cnt_next == TIMEOUT_C) begin
          state_next  = S_HOLD;
          cap_en      = 1'b1;
          cap_resp    = 2'd3;
          cap_timeout = 1'b1;
        end
      end
      S_HOLD: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Port registers trail the state by one edge, so CMD reaches the port two
  // edges after the request is accepted.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= '0;
      req_cmd_reg     <= '0;
      req_data_reg    <= '0;
      res_valid_reg   <= 1'b0;
      res_resp_reg    <= '0;
      res_data_reg    <= '0;
      res_timeout_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      busy_reg     <= (state_next != S_IDLE);
      case (state_reg)
        S_CMD: begin
          req_cmd_reg  <= cur_cmd_reg;
          req_data_reg <= cur_op1_reg;
        end
        S_DATA: begin
          req_cmd_reg  <= 4'd0;
          req_data_reg <= cur_op2_reg;
        end
        default: begin
          req_cmd_reg  <= 4'd0;
          req_data_reg <= 32'd0;
        end
      endcase
      if (cap_en) begin
        res_valid_reg   <= 1'b1;
        res_resp_reg    <= cap_resp;
        res_data_reg    <= cap_data;
        res_timeout_reg <= cap_timeout;
      end else if (state_reg == S_HOLD && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready     = in_ready_reg;
  assign req_cmd_out  = req_cmd_reg;
  assign req_data_out = req_data_reg;
  assign res_valid    = res_valid_reg;
  assign res_resp     = res_resp_reg;
  assign res_data     = res_data_reg;
  assign res_timeout  = res_timeout_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_calc1_port_seq.sv
// Bench for calc1_port_seq: a calc1 responder model on the port, a result
// scoreboard, table vectors, hand sequences for corner cases, and random traffic.
module tb_calc1_port_seq;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        c_clk, reset, in_valid, in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_op1, in_op2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        res_valid, res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        res_timeout, busy;

  calc1_port_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_resp(res_resp), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int port_cmds = 0;
  int res_cnt = 0;
  int data_cyc = 0;
  int rphase = 0;
  bit mute = 1'b0;
  logic [34:0] expq[$];

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[7];

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  always @(posedge c_clk) cyc <= cyc + 1;

  // calc1 behaviour: 1=add, 2=sub, anything else is rejected with resp 2
  function automatic logic [33:0] calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (cmd)
      4'd1:    return {(s[32] ? 2'd2 : 2'd1), s[31:0]};
      4'd2:    return {((b > a) ? 2'd2 : 2'd1), a - b};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  function automatic logic [34:0] expect_of(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    if (mute) return {1'b1, 2'd3, 32'd0};
    return {1'b0, calc(cmd, a, b)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Responder: records CMD/DATA port cycles and answers 3 cycles after DATA.
  initial begin
    logic [3:0]  r_cmd;
    logic [31:0] r_op1, r_op2;
    logic [33:0] m;
    int rcnt;
    out_resp = 2'd0;
    out_data = 32'd0;
    r_cmd = 4'd0; r_op1 = 32'd0; r_op2 = 32'd0; rcnt = 0;
    forever begin
      tick();
      if (reset) begin
        rphase = 0;
        out_resp = 2'd0;
        out_data = 32'd0;
      end else begin
        case (rphase)
          0: if (req_cmd_out != 4'd0) begin
               r_cmd = req_cmd_out;
               r_op1 = req_data_out;
               port_cmds++;
               rphase = 1;
             end
          1: begin
               check("port_data_cmd", 64'(req_cmd_out), 64'(0));
               r_op2 = req_data_out;
               data_cyc = cyc;
               rcnt = 0;
               rphase = 2;
             end
          2: begin
               rcnt++;
               if (rcnt == 3) begin
                 if (!mute) begin
                   m = calc(r_cmd, r_op1, r_op2);
                   out_resp = m[33:32];
                   out_data = m[31:0];
                 end
                 rphase = 3;
               end
             end
          default: begin
               out_resp = 2'd0;
               out_data = 32'd0;
               rphase = 0;
             end
        endcase
      end
    end
  end

  // One clock: note handshakes seen before the edge, then update the scoreboard.
  task automatic cycle_step();
    bit acc, hs;
    logic [34:0] got, want;
    logic [3:0]  c;
    logic [31:0] a, b;
    acc = in_valid && in_ready;
    hs  = res_valid && res_ready;
    got = {res_timeout, res_resp, res_data};
    c = in_cmd; a = in_op1; b = in_op2;
    tick();
    if (acc) begin
      in_valid = 1'b0;
      if (c != 4'd0) expq.push_back(expect_of(c, a, b));
    end
    if (hs) begin
      res_cnt++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL result_order: got unexpected result 0x%0h, expected none", got);
      end else begin
        want = expq.pop_front();
        $display("txn %0d: resp=%0d data=0x%08h timeout=%0d", res_cnt, got[33:32], got[31:0], got[34]);
        if (got !== want) begin
          errors++;
          $display("FAIL result: got 0x%0h, expected 0x%0h", got, want);
        end
      end
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_cmd = c; in_op1 = a; in_op2 = b; in_valid = 1'b1;
    while (in_valid && n < 100) begin
      cycle_step();
      n++;
    end
    check("push_accept", 64'(in_valid), 64'(0));
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 60) begin
      cycle_step();
      n++;
    end
    check(name, 64'(res_valid), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while ((expq.size() != 0 || in_valid) && n < 400) begin
      cycle_step();
      n++;
    end
    repeat (3) cycle_step();
    res_ready = 1'b0;
    check("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [35:0] snap;
    int base_p, base_r;

    vecs[0] = '{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000};
    vecs[1] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 2'd2, 32'h0000_0000};
    vecs[2] = '{4'd2, 32'd10,        32'd3,         2'd1, 32'd7};
    vecs[3] = '{4'd2, 32'd3,         32'd10,        2'd2, 32'hFFFF_FFF9};
    vecs[4] = '{4'd3, 32'd5,         32'd6,         2'd2, 32'd0};
    vecs[5] = '{4'd15, 32'd1,        32'd2,         2'd2, 32'd0};
    vecs[6] = '{4'd1, 32'h1234_5678, 32'h1111_1111, 2'd1, 32'h2345_6789};

    reset = 1'b1; in_valid = 1'b0; in_cmd = 4'd0; in_op1 = 32'd0; in_op2 = 32'd0; res_ready = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", 64'({in_ready, res_valid, res_timeout, busy, res_resp, req_cmd_out}), 64'(0));
    check("reset_data", {req_data_out, res_data}, 64'(0));
    reset = 1'b0;
    tick();
    check("ready_after_reset", 64'({in_ready, busy}), 64'(2'b10));

    // single add: port sequence and timing
    push(4'd1, 32'd1, 32'h01FF_FFFF);
    check("no_cmd_at_accept", 64'(req_cmd_out), 64'(0));
    cycle_step();
    check("cmd_not_yet", 64'({busy, req_cmd_out}), 64'({1'b1, 4'd0}));
    cycle_step();
    check("cmd_phase", 64'({req_cmd_out, req_data_out}), 64'({4'd1, 32'd1}));
    cycle_step();
    check("data_phase", 64'({req_cmd_out, req_data_out}), 64'({4'd0, 32'h01FF_FFFF}));
    cycle_step();
    check("wait_phase", 64'({req_cmd_out, req_data_out}), 64'(0));
    wait_res("add_wait");
    check("add_result", 64'({res_valid, res_timeout, res_resp, res_data}), 64'({1'b1, 1'b0, 2'd1, 32'h0200_0000}));
    res_ready = 1'b1;
    cycle_step();
    res_ready = 1'b0;
    check("after_handshake", 64'({res_valid, busy}), 64'(0));

    // table vectors
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].cmd, vecs[i].a, vecs[i].b);
      wait_res("vec_wait");
      check($sformatf("vec%0d", i), 64'({res_timeout, res_resp, res_data}), 64'({1'b0, vecs[i].resp, vecs[i].data}));
      res_ready = 1'b1;
      cycle_step();
      res_ready = 1'b0;
    end

    // timeout, then late responses are ignored
    mute = 1'b1;
    push(4'd1, 32'hFFFF_FFFF, 32'd1);
    wait_res("timeout_wait");
    check("timeout_result", 64'({res_timeout, res_resp, res_data}), 64'({1'b1, 2'd3, 32'd0}));
    check("timeout_cycles", 64'(cyc - data_cyc), 64'(TIMEOUT));
    out_resp = 2'd2; out_data = 32'h0000_ABCD;
    cycle_step();
    out_resp = 2'd0; out_data = 32'd0;
    check("late_resp_hold", 64'({res_valid, res_timeout, res_resp, res_data}), 64'({1'b1, 1'b1, 2'd3, 32'd0}));
    res_ready = 1'b1;
    cycle_step();
    res_ready = 1'b0;
    out_resp = 2'd2; out_data = 32'h0000_1234;
    cycle_step();
    out_resp = 2'd0; out_data = 32'd0;
    repeat (3) cycle_step();
    check("late_resp_idle", 64'({res_valid, busy}), 64'(0));
    mute = 1'b0;

    // FIFO full with FSM stalled in HOLD
    push(4'd1, 32'd100, 32'd1);
    wait_res("blocker_wait");
    for (int i = 0; i < 4; i++) push(4'd1, 32'(i) + 32'd1, 32'h0000_1000);
    check("full_after_4", 64'(in_ready), 64'(0));
    check("queued_5", 64'(expq.size()), 64'(5));
    in_cmd = 4'd1; in_op1 = 32'd500; in_op2 = 32'd5; in_valid = 1'b1;
    repeat (3) begin
      cycle_step();
      check("held_off", 64'({in_valid, in_ready}), 64'(2'b10));
    end
    base_r = res_cnt;
    drain();
    check("order_count", 64'(res_cnt - base_r), 64'(6));

    // result held with a request queued behind it
    push(4'd2, 32'd50, 32'd8);
    push(4'd1, 32'd7, 32'd9);
    wait_res("hold_wait");
    snap = {res_valid, res_timeout, res_resp, res_data};
    repeat (10) begin
      cycle_step();
      check("hold_stable", 64'({res_valid, res_timeout, res_resp, res_data}), 64'(snap));
      check("hold_no_cmd", 64'(req_cmd_out), 64'(0));
    end
    res_ready = 1'b1;
    cycle_step();
    res_ready = 1'b0;
    check("second_cmd_h0", 64'(req_cmd_out), 64'(0));
    cycle_step();
    check("second_cmd_h1", 64'(req_cmd_out), 64'(0));
    cycle_step();
    check("second_cmd_h2", 64'({req_cmd_out, req_data_out}), 64'({4'd1, 32'd7}));
    drain();

    // zero command is dropped silently
    base_p = port_cmds;
    base_r = res_cnt;
    res_ready = 1'b1;
    push(4'd1, 32'd3, 32'd4);
    push(4'd0, 32'd9, 32'd9);
    push(4'd3, 32'd5, 32'd6);
    drain();
    check("cmd0_port_cycles", 64'(port_cmds - base_p), 64'(2));
    check("cmd0_results", 64'(res_cnt - base_r), 64'(2));

    // reset during WAIT
    push(4'd1, 32'd7, 32'd8);
    repeat (4) cycle_step();
    check("in_wait", 64'({busy, res_valid, req_cmd_out}), 64'({1'b1, 1'b0, 4'd0}));
    #3;
    reset = 1'b1;
    #1;
    check("mid_reset_ctrl", 64'({in_ready, res_valid, res_timeout, busy, res_resp, req_cmd_out}), 64'(0));
    check("mid_reset_data", {req_data_out, res_data}, 64'(0));
    expq.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    out_resp = 2'd1; out_data = 32'h0000_0055;
    cycle_step();
    out_resp = 2'd0; out_data = 32'd0;
    repeat (3) cycle_step();
    check("no_result_after_reset", 64'({res_valid, busy}), 64'(0));
    push(4'd1, 32'h0000_0100, 32'h0000_0023);
    wait_res("post_reset_wait");
    check("post_reset_result", 64'({res_timeout, res_resp, res_data}), 64'({1'b0, 2'd1, 32'h0000_0123}));
    drain();

    // random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        in_cmd = 4'($urandom_range(0, 4));
        in_op1 = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 31))) : $urandom;
        in_op2 = $urandom;
        in_valid = 1'b1;
      end
      res_ready = 1'($urandom_range(0, 1));
      cycle_step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
